payload_slot_allocator: RTL

- Owns the free/busy state of the issue payload RAM that sits between Dispatch and Wakeup/Select.
- Grants Dispatch one payload RAM slot per cycle; this is the index driven as payload_ram_index alongside disp_uop/disp_valid.
- Select returns slots as uops issue. Flush returns every slot.
- Back-pressures Dispatch when no slot is free.

---
 rtl/payload_slot_allocator_if.sv | 30 +++
 rtl/payload_slot_allocator.sv | 112 +++++++++++
 2 files changed

// File: rtl/payload_slot_allocator_if.sv
// Dispatch/Select-facing signal bundle for the issue payload RAM slot allocator.
// master = Dispatch/Select side, slave = allocator.
interface payload_slot_allocator_if #(
    parameter int NUM_ENTRIES = 16,
    parameter int NUM_FREE    = 2
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

    logic                      disp_valid;
    logic                      disp_ready;
    logic                      alloc_fire;
    logic [IDX_W-1:0]          alloc_idx;
    logic [NUM_FREE-1:0]       free_valid;
    logic [NUM_FREE*IDX_W-1:0] free_idx;
    logic                      flush;
    logic [CNT_W-1:0]          free_count;
    logic                      full;
    logic                      empty;

    modport master (
        output disp_valid, free_valid, free_idx, flush,
        input  disp_ready, alloc_fire, alloc_idx, free_count, full, empty
    );

    modport slave (
        input  disp_valid, free_valid, free_idx, flush,
        output disp_ready, alloc_fire, alloc_idx, free_count, full, empty
    );
endinterface

// File: rtl/payload_slot_allocator.sv
// Free/busy tracker for the issue payload RAM: one grant per cycle, multi-port release, flush.
// Optional PAYLOAD_ALLOC_ROUND_ROBIN_EN selects slots round-robin instead of lowest-first.
module payload_slot_allocator #(
    parameter int NUM_ENTRIES = 16,
    parameter int NUM_FREE    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    payload_slot_allocator_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

    logic [NUM_ENTRIES-1:0] free_map;
    logic [NUM_ENTRIES-1:0] free_set;
    logic [NUM_ENTRIES-1:0] alloc_clr;
    logic [CNT_W-1:0]       free_count;
    logic [IDX_W-1:0]       alloc_idx;
    logic                   full;
    logic                   alloc_fire;

    always_comb begin
        free_count = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            free_count = free_count + CNT_W'(free_map[i]);
    end

`ifdef PAYLOAD_ALLOC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;

    // Search upward from rr_ptr; IDX_W-bit addition wraps because depth is a power of two.
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        alloc_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            cand = rr_ptr + IDX_W'(k);
            if (!found && free_map[cand]) begin
                alloc_idx = cand;
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (bus.flush)
            rr_ptr <= '0;
        else if (alloc_fire)
            rr_ptr <= alloc_idx + 1'b1;
    end
`else
    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        alloc_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--)
            if (free_map[i])
                alloc_idx = IDX_W'(i);
    end
`endif

    assign full       = (free_count == '0);
    assign alloc_fire = bus.disp_valid & bus.disp_ready;

    assign bus.free_count = free_count;
    assign bus.full       = full;
    assign bus.empty      = (free_count == CNT_W'(NUM_ENTRIES));
    assign bus.disp_ready = !full & !bus.flush;
    assign bus.alloc_fire = alloc_fire;
    assign bus.alloc_idx  = alloc_idx;

    always_comb begin
        free_set  = '0;
        alloc_clr = '0;
        for (int k = 0; k < NUM_FREE; k++)
            if (bus.free_valid[k])
                free_set[bus.free_idx[k*IDX_W +: IDX_W]] = 1'b1;
        if (alloc_fire)
            alloc_clr[alloc_idx] = 1'b1;
    end

    // Releases land in free_map only; they become grantable the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            free_map <= '1;
        else if (bus.flush)
            free_map <= '1;
        else
            free_map <= (free_map & ~alloc_clr) | free_set;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_FREE; k++) begin
                if (bus.free_valid[k]) begin
                    assert (int'(bus.free_idx[k*IDX_W +: IDX_W]) < NUM_ENTRIES)
                        else $error("free_idx out of range on port %0d", k);
                    assert (!free_map[bus.free_idx[k*IDX_W +: IDX_W]])
                        else $error("release of already-free slot %0d on port %0d",
                                    bus.free_idx[k*IDX_W +: IDX_W], k);
                end
            end
            assert (!(alloc_fire && full))
                else $error("alloc_fire while full");
        end
    end
`endif
endmodule
